// File: rtl/adder_sum_stage_pkg.sv
// Shared definitions for the parallel-prefix adder: operand width, result-word
// layout ({flags, sum}) and the flag-vector type.
package adder_sum_stage_pkg;

    localparam int unsigned LEN_DATA  = 64;
    localparam int unsigned LEN_FLAGS = 4;

    // Sum occupies the low LEN_DATA bits of the result word.
    localparam int unsigned OFS_SUM = 0;

    // Flag positions inside the flag vector; the vector sits directly above the sum.
    localparam int unsigned FLAG_COUT = 0;
    localparam int unsigned FLAG_OVF  = 1;
    localparam int unsigned FLAG_ZERO = 2;
    localparam int unsigned FLAG_NEG  = 3;

    // Packed so that cout lands in bit 0 and neg in bit 3.
    typedef struct packed {
        logic neg;
        logic zero;
        logic ovf;
        logic cout;
    } flags_t;

    // Absolute bit offset of a flag in a result word for a given operand width.
    function automatic int unsigned ofs_flag(input int unsigned len_data,
                                             input int unsigned flag);
        return len_data + flag;
    endfunction

endpackage

// File: rtl/adder_sum_logic.sv
// Carry, sum and flag generation from resolved prefix G/P vectors.
// Purely combinational.
module adder_sum_logic
    import adder_sum_stage_pkg::*;
#(
    parameter int unsigned LEN_DATA = adder_sum_stage_pkg::LEN_DATA
) (
    input  logic [LEN_DATA-1:0] i_g,
    input  logic [LEN_DATA-1:0] i_p,
    input  logic [LEN_DATA-1:0] i_hs,
    input  logic                i_cin,
    output logic [LEN_DATA-1:0] o_sum_c,
    output flags_t              o_flags_c
);

    logic [LEN_DATA:0]   w_carry;
    logic [LEN_DATA-1:0] w_sum;

    // Carry into bit i is the group generate of [i-1:0], or its propagate with cin.
    assign w_carry[0]          = i_cin;
    assign w_carry[LEN_DATA:1] = i_g | (i_p & {LEN_DATA{i_cin}});

    assign w_sum = i_hs ^ w_carry[LEN_DATA-1:0];

    assign o_sum_c        = w_sum;
    assign o_flags_c.cout = w_carry[LEN_DATA];
    assign o_flags_c.ovf  = w_carry[LEN_DATA] ^ w_carry[LEN_DATA-1];
    assign o_flags_c.zero = ~|w_sum;
    assign o_flags_c.neg  = w_sum[LEN_DATA-1];

endmodule

// File: rtl/adder_sum_stage.sv
// Final registered stage of the prefix adder: sum/flag generation followed by
// a valid/ready output register.
// Optional macro ADDER_SUM_SKID_EN: adds a skid register so in_ready comes
// straight from a flop (two-entry buffer). Default: single output register.
module adder_sum_stage
    import adder_sum_stage_pkg::*;
#(
    parameter int unsigned LEN_DATA = adder_sum_stage_pkg::LEN_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] g_in,
    input  logic [LEN_DATA-1:0] p_in,
    input  logic [LEN_DATA-1:0] hs_in,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] sum_out,
    output logic                cout,
    output logic                ovf,
    output logic                zero,
    output logic                neg
);

    localparam int unsigned LEN_RES   = LEN_DATA + LEN_FLAGS;
    localparam int unsigned OFS_COUT  = ofs_flag(LEN_DATA, FLAG_COUT);
    localparam int unsigned OFS_OVF   = ofs_flag(LEN_DATA, FLAG_OVF);
    localparam int unsigned OFS_ZERO  = ofs_flag(LEN_DATA, FLAG_ZERO);
    localparam int unsigned OFS_NEG   = ofs_flag(LEN_DATA, FLAG_NEG);

    logic [LEN_DATA-1:0] w_sum;
    flags_t              w_flags;
    logic [LEN_RES-1:0]  w_res;
    logic                w_push;
    logic                w_pop;

    logic [LEN_RES-1:0]  r_out;
    logic                r_out_valid;

    adder_sum_logic #(
        .LEN_DATA (LEN_DATA)
    ) u_logic (
        .i_g       (g_in),
        .i_p       (p_in),
        .i_hs      (hs_in),
        .i_cin     (cin),
        .o_sum_c   (w_sum),
        .o_flags_c (w_flags)
    );

    assign w_res = {w_flags, w_sum};
    assign w_pop = r_out_valid & out_ready;

`ifdef ADDER_SUM_SKID_EN

    logic [LEN_RES-1:0] r_skid;
    logic               r_skid_full;

    assign in_ready = ~r_skid_full;
    assign w_push   = in_valid & ~r_skid_full;

    // Output register plus skid entry; skid refills the output on the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
        end else if (r_skid_full) begin
            if (w_pop) begin
                r_out       <= r_skid;
                r_skid_full <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_out_valid || w_pop) begin
                r_out       <= w_res;
                r_out_valid <= 1'b1;
            end else begin
                r_skid      <= w_res;
                r_skid_full <= 1'b1;
            end
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

`else

    assign in_ready = ~r_out_valid | out_ready;
    assign w_push   = in_valid & in_ready;

    // Single output register; a new result replaces the old one on a simultaneous pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_push) begin
            r_out       <= w_res;
            r_out_valid <= 1'b1;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

`endif

    assign out_valid = r_out_valid;
    assign sum_out   = r_out[OFS_SUM +: LEN_DATA];
    assign cout      = r_out[OFS_COUT];
    assign ovf       = r_out[OFS_OVF];
    assign zero      = r_out[OFS_ZERO];
    assign neg       = r_out[OFS_NEG];

endmodule
